priority_enc_rr: RTL and testbench
==================================

# priority_enc_rr

Parametrised, registered N-input priority encoder with sticky request capture, per-input masking, selectable fixed or round-robin priority, and a valid/ready output handshake. It generalises the 4-input fixed-priority encoder to any width. Requests are held until their index has been delivered downstream. The block sits between interrupt/event sources and a single consumer that services one index at a time.

## Interface
- N, 8, number of request inputs (N ≥ 2, need not be a power of 2)
- W, $clog2(N), index width (derived, do not override)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N  request pulses or levels; sampled every edge
- mask  input  N  1 = input eligible for selection; applied at selection only
- mode  input  1  0 = fixed priority (bit 0 highest); 1 = round-robin
- out_ready  input  1  consumer accepts the current index
- out_valid  output  1  out_idx/out_onehot hold a selected request
- out_idx  output  W  binary index of the selected request
- out_onehot  output  N  one-hot form of out_idx; all zero when out_valid = 0
- pend  output  N  captured, not-yet-selected requests (register view)

## Operation
- State:
  - pend[N-1:0]
  - output register (out_valid, out_idx, out_onehot)
  - round-robin pointer ptr[W-1:0], range 0..N-1
- Capture:
  - A req bit sets pend on the next edge, whether or not it is masked.
  - A req bit is coalesced (no additional grant) if that bit is already pending, or is held in the output register with out_valid = 1, including the acceptance cycle.
- Stage free: when out_valid = 0, or when out_valid = 1 and out_ready = 1 (acceptance).
- Candidates: (pend | req) & mask. The bit being accepted this cycle is excluded.
- Selection (only when the stage is free):
  - Fixed mode: the lowest-index candidate wins.
  - Round-robin mode: search from index ptr upward, wrapping N-1 → 0; the first candidate wins.
  - On a win at index k: load out_idx = k, out_onehot = 1<<k, out_valid = 1; clear pend[k] on the same edge.
  - With no candidate: out_valid = 0, out_onehot = 0, out_idx holds its previous value.
- Hold: while out_valid = 1 and out_ready = 0, all outputs stay stable. Higher-priority arrivals do not pre-empt the held index.
- Pointer:
  - In round-robin mode, a load of index k sets ptr = (k+1) mod N. k = N-1 wraps ptr to 0, including for non-power-of-2 N.
  - Fixed mode never changes ptr.
  - A mode change takes effect at the next selection; ptr is not reset by a mode change.
- Masked pending bits stay in pend indefinitely and become eligible on the first cycle their mask bit is 1.
- Update rule: pend_next = (pend | req) & ~loaded_onehot & ~inflight_onehot. inflight_onehot is the output register contents when out_valid = 1 (this implements coalescing).

## Timing
- Reset (async assert; release synchronous to clk):
  - pend = 0, out_valid = 0, out_idx = 0, out_onehot = 0, ptr = 0.
  - Assertion mid-operation drops all pending and in-flight requests immediately.
- Latency: a req sampled at edge e appears on out_valid/out_idx after edge e when the stage is free. The pend register is bypassed for this path.
- Throughput: one index per cycle while out_ready = 1 and candidates exist. Back-to-back acceptance produces no bubble.
- Handshake: a transfer occurs on an edge where out_valid = 1 and out_ready = 1. out_valid never drops without a transfer, except on reset.
- pend output reflects the register and lags req by one edge.

## Test plan
- N=8, fixed mode, out_ready=1; req=8'b1010_0100 for one cycle → out_idx 2, 5, 7 on three consecutive cycles; then out_valid=0 and pend=0.
- N=8, round-robin mode, req held at 8'hFF, out_ready=1 → out_idx sequence 0,1,2…7,0 with ptr wrapping.
- N=5 (non-power-of-2), round-robin mode; grant index 4 → ptr=0; next grant among {0,3} is 0.
- Backpressure: out_ready=0, out_idx=3 held; pulse req[0] and req[3] → outputs stable, pend=8'b0000_0001, req[3] coalesced; set out_ready=1 → out_idx 0 follows, then out_valid=0.
- Mask: req=8'h81, mask=8'h80, fixed mode → out_idx 7 only, pend[0] retained; set mask=8'hFF → out_idx 0 next cycle.
- Reset: assert rst asynchronously while out_valid=1 and pend=8'h0F → outputs and pend zero before the next edge; no grants after release until a new req arrives.

Source files
------------

// File: rtl/priority_enc_rr.sv
// Registered N-input priority encoder (fixed or round-robin) with sticky capture and per-input masking.
// Latency: req sampled at edge e is presented after edge e. Backpressure: outputs hold while out_ready=0 and new requests are parked in pend.
module priority_enc_rr #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [N-1:0] pend
);

    logic [N-1:0]   pend_q, pend_d;
    logic           vld_q, vld_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [N-1:0]   oh_q, oh_d;
    logic [W-1:0]   ptr_q, ptr_d;

    logic [N-1:0]   inflight;
    logic [N-1:0]   cand;
    logic [N-1:0]   loaded;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   base;
    logic [W-1:0]   off;
    logic [W:0]     sum;
    logic [W-1:0]   win;
    logic [N-1:0]   win_oh;
    logic           found;
    logic           stage_free;

    always_comb begin
        inflight   = vld_q ? oh_q : '0;
        stage_free = !vld_q || out_ready;
        // The in-flight index is never a candidate: that is what coalesces repeats.
        cand       = (pend_q | req) & mask & ~inflight;

        // Rotate so the search start lands at bit 0; fixed mode simply starts at 0.
        base = mode ? ptr_q : '0;
        dbl  = {cand, cand} >> base;
        rot  = dbl[N-1:0];

        found = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = W'(i);
            end
        end

        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        win    = sum[W-1:0];
        win_oh = {{(N-1){1'b0}}, 1'b1} << win;

        vld_d  = vld_q;
        idx_d  = idx_q;
        oh_d   = oh_q;
        ptr_d  = ptr_q;
        loaded = '0;
        if (stage_free) begin
            if (found) begin
                vld_d  = 1'b1;
                idx_d  = win;
                oh_d   = win_oh;
                loaded = win_oh;
                if (mode) begin
                    ptr_d = (win == W'(N - 1)) ? '0 : win + W'(1);
                end
            end else begin
                vld_d = 1'b0;
                oh_d  = '0;
            end
        end

        pend_d = (pend_q | req) & ~loaded & ~inflight;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            vld_q  <= 1'b0;
            idx_q  <= '0;
            oh_q   <= '0;
            ptr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            vld_q  <= vld_d;
            idx_q  <= idx_d;
            oh_q   <= oh_d;
            ptr_q  <= ptr_d;
        end
    end

    assign out_valid  = vld_q;
    assign out_idx    = idx_q;
    assign out_onehot = oh_q;
    assign pend       = pend_q;

endmodule

// File: tb/tb_priority_enc_rr.sv
// Bench for priority_enc_rr: N=8 and N=5 instances against a queue-free arithmetic reference model.
module tb_priority_enc_rr;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic [7:0] req_a, mask_a;
    logic       mode_a, rdy_a;
    logic       v_a;
    logic [2:0] idx_a;
    logic [7:0] oh_a, pend_a;

    logic [4:0] req_b, mask_b;
    logic       mode_b, rdy_b;
    logic       v_b;
    logic [2:0] idx_b;
    logic [4:0] oh_b, pend_b;

    priority_enc_rr #(.N(8)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .mask(mask_a), .mode(mode_a),
        .out_ready(rdy_a), .out_valid(v_a), .out_idx(idx_a),
        .out_onehot(oh_a), .pend(pend_a)
    );

    priority_enc_rr #(.N(5)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .mask(mask_b), .mode(mode_b),
        .out_ready(rdy_b), .out_valid(v_b), .out_idx(idx_b),
        .out_onehot(oh_b), .pend(pend_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one entry per instance.
    bit [7:0] m_pend[2];
    bit       m_ov[2];
    int       m_idx[2];
    int       m_ptr[2];
    int       m_n[2] = '{8, 5};

    function automatic void mreset();
        for (int u = 0; u < 2; u++) begin
            m_pend[u] = '0;
            m_ov[u]   = 1'b0;
            m_idx[u]  = 0;
            m_ptr[u]  = 0;
        end
    endfunction

    function automatic void mstep(int u, bit [7:0] rq, bit [7:0] mk, bit md, bit rdy);
        int       n = m_n[u];
        int       k;
        int       c;
        bit [7:0] all;
        bit [7:0] infl;
        bit [7:0] avail;
        bit [7:0] got;
        all   = 8'((1 << n) - 1);
        rq    = rq & all;
        infl  = m_ov[u] ? 8'(1 << m_idx[u]) : 8'h00;
        avail = (m_pend[u] | rq) & mk & ~infl;
        got   = 8'h00;
        if (!m_ov[u] || rdy) begin
            k = -1;
            for (int s = 0; s < n; s++) begin
                c = md ? (m_ptr[u] + s) % n : s;
                if (k < 0 && avail[c]) k = c;
            end
            if (k >= 0) begin
                m_ov[u]  = 1'b1;
                m_idx[u] = k;
                got      = 8'(1 << k);
                if (md) m_ptr[u] = (k + 1) % n;
            end else begin
                m_ov[u] = 1'b0;
            end
        end
        m_pend[u] = (m_pend[u] | rq) & ~infl & ~got;
    endfunction

    task automatic compare();
        check("a_valid",  {31'b0, v_a}, {31'b0, m_ov[0]});
        check("a_idx",    {29'b0, idx_a}, m_idx[0]);
        check("a_onehot", {24'b0, oh_a}, m_ov[0] ? (32'd1 << m_idx[0]) : 32'd0);
        check("a_pend",   {24'b0, pend_a}, {24'b0, m_pend[0]});
        check("b_valid",  {31'b0, v_b}, {31'b0, m_ov[1]});
        check("b_idx",    {29'b0, idx_b}, m_idx[1]);
        check("b_onehot", {27'b0, oh_b}, m_ov[1] ? (32'd1 << m_idx[1]) : 32'd0);
        check("b_pend",   {27'b0, pend_b}, {24'b0, m_pend[1]});
    endtask

    task automatic cycle();
        @(posedge clk);
        mstep(0, req_a, mask_a, mode_a, rdy_a);
        mstep(1, {3'b0, req_b}, {3'b0, mask_b}, mode_b, rdy_b);
        #1 compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mreset();
        #1 compare();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_a = '0; mask_a = 8'hFF; mode_a = 1'b0; rdy_a = 1'b1;
        req_b = '0; mask_b = 5'h1F; mode_b = 1'b0; rdy_b = 1'b1;
        mreset();
        do_reset();
        check("rst_valid", {31'b0, v_a}, 32'd0);
        check("rst_pend",  {24'b0, pend_a}, 32'd0);

        // Fixed priority drain of a single burst
        req_a = 8'hA4;
        cycle(); check("fix_first", {29'b0, idx_a}, 32'd2);
        req_a = 8'h00;
        cycle(); check("fix_second", {29'b0, idx_a}, 32'd5);
        cycle(); check("fix_third", {29'b0, idx_a}, 32'd7);
        cycle(); check("fix_idle", {31'b0, v_a}, 32'd0);
        check("fix_pend", {24'b0, pend_a}, 32'd0);

        // Round-robin over all-ones, wrapping 7 -> 0
        do_reset();
        mode_a = 1'b1; req_a = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            cycle(); check("rr_seq", {29'b0, idx_a}, i % 8);
        end
        req_a = 8'h00; mode_a = 1'b0;

        // Backpressure: hold index 3, coalesce req[3], park req[0]
        do_reset();
        rdy_a = 1'b0; req_a = 8'h08;
        cycle(); check("bp_load", {29'b0, idx_a}, 32'd3);
        req_a = 8'h09;
        cycle(); check("bp_hold", {29'b0, idx_a}, 32'd3);
        check("bp_pend", {24'b0, pend_a}, 32'h01);
        req_a = 8'h00;
        cycle(); check("bp_stable", {24'b0, oh_a}, 32'h08);
        rdy_a = 1'b1;
        cycle(); check("bp_next", {29'b0, idx_a}, 32'd0);
        cycle(); check("bp_done", {31'b0, v_a}, 32'd0);

        // Masking keeps bit 0 pending until unmasked
        do_reset();
        mask_a = 8'h80; req_a = 8'h81;
        cycle(); check("mask_sel", {29'b0, idx_a}, 32'd7);
        check("mask_pend", {24'b0, pend_a}, 32'h01);
        mask_a = 8'hFF; req_a = 8'h00;
        cycle(); check("mask_unmask", {29'b0, idx_a}, 32'd0);
        cycle(); check("mask_done", {31'b0, v_a}, 32'd0);

        // Asynchronous reset mid-operation
        do_reset();
        rdy_a = 1'b0; req_a = 8'h10;
        cycle();
        req_a = 8'h0F;
        cycle(); check("ar_pend_pre", {24'b0, pend_a}, 32'h0F);
        req_a = 8'h00;
        #2 rst = 1'b1;
        mreset();
        #1 check("ar_valid", {31'b0, v_a}, 32'd0);
        check("ar_pend", {24'b0, pend_a}, 32'd0);
        check("ar_onehot", {24'b0, oh_a}, 32'd0);
        #2 rst = 1'b0;
        rdy_a = 1'b1;
        cycle(); cycle(); check("ar_quiet", {31'b0, v_a}, 32'd0);

        // Non-power-of-two width round-robin wrap
        do_reset();
        mode_b = 1'b1; req_b = 5'h10;
        cycle(); check("n5_four", {29'b0, idx_b}, 32'd4);
        req_b = 5'h09;
        cycle(); check("n5_wrap", {29'b0, idx_b}, 32'd0);
        req_b = 5'h00;
        cycle(); check("n5_three", {29'b0, idx_b}, 32'd3);
        cycle(); check("n5_idle", {31'b0, v_b}, 32'd0);

        // Randomized traffic on both instances
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            req_a  = 8'($urandom & $urandom);
            mask_a = 8'($urandom | $urandom);
            rdy_a  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode_a = ~mode_a;
            req_b  = 5'($urandom & $urandom);
            mask_b = 5'($urandom | $urandom);
            rdy_b  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode_b = ~mode_b;
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
